// File: rtl/load_store_unit_if.sv
// Request/response handshake between CPU and the load/store unit, plus the unit's data-RAM port.
// The slave modport belongs to the LSU. The master modport is the environment: the CPU side and the RAM.
interface load_store_unit_if #(
  parameter int SIZE = 1024
);
  localparam int ADDR_W = $clog2(SIZE);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_data_write;
  logic [31:0]       ram_data_read;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_data_read,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_data_write
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_data_read,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_data_write
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: checks the request, does sub-word read-modify-write, and extends load lanes.
// Latency from accept to response is 1 for an error, 2 for a load or SW, and 3 for SB/SH; req_ready is high only in IDLE.
module load_store_unit #(
  parameter int SIZE = 1024
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  localparam int ADDR_W = $clog2(SIZE);

  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~addr[0];
      3'b010:  ok = (addr[1:0] == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~addr[0];
      default: ok = 1'b0;
    endcase
    return ok && (addr[31:ADDR_W] == '0);
  endfunction

  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Only the addressed lane is replaced; the other bytes come from the RAM word just read.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (f3 == 3'b000) m[{off, 3'b000} +: 8] = wd[7:0];
    else              m[{off[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      lat_funct3         <= '0;
      lat_off            <= '0;
      lat_wdata          <= '0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= '0;
      bus.resp_err       <= 1'b0;
      bus.ram_we         <= 1'b0;
      bus.ram_addr       <= '0;
      bus.ram_data_write <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            lat_funct3    <= bus.req_funct3;
            lat_off       <= bus.req_addr[1:0];
            lat_wdata     <= bus.req_wdata[15:0];
            bus.ram_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            bus.req_ready <= 1'b0;
            if (!req_legal(bus.req_we, bus.req_funct3, bus.req_addr)) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              state          <= DONE;
            end else if (!bus.req_we) begin
              state <= LOAD;
            end else if (bus.req_funct3 == 3'b010) begin
              bus.ram_data_write <= bus.req_wdata;
              bus.ram_we         <= 1'b1;
              state              <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        LOAD: begin
          bus.resp_rdata <= load_lane(bus.ram_data_read, lat_funct3, lat_off);
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= DONE;
        end
        READ: begin
          bus.ram_data_write <= store_merge(bus.ram_data_read, lat_funct3, lat_off, lat_wdata);
          bus.ram_we         <= 1'b1;
          state              <= WRITE;
        end
        WRITE: begin
          bus.ram_we     <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          state          <= DONE;
        end
        DONE: begin
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          bus.ram_we     <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases, then random traffic checked against a byte-array model.
// The RAM is modelled as a word array with a combinational read and a write on posedge.
module tb_load_store_unit;
  localparam int SIZE   = 1024;
  localparam int ADDR_W = $clog2(SIZE);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fill = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.SIZE(SIZE)) bus();
  load_store_unit #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [31:0] mem [SIZE/4];
  logic [7:0]  ref_mem [SIZE];
  int vectors = 0, miscompares = 0, we_cnt = 0, acc_cnt = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.ram_data_read = mem[bus.ram_addr[ADDR_W-1:2]];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < SIZE/4; i++) mem[i] = init_word(i);
    end else if (bus.ram_we) begin
      mem[bus.ram_addr[ADDR_W-1:2]] = bus.ram_data_write;
    end
    if (bus.ram_we) we_cnt++;
    if (bus.req_valid && bus.req_ready) acc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a & 32'hFFFF_FFFC);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // The reference model treats memory as bytes and knows nothing about states or word lanes.
  task automatic model_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output bit err,
                              output int lat);
    int nb;
    bit legal_f3;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    legal_f3 = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal_f3 || ((a % nb) != 0) || (a >= SIZE);
    rd = 32'h0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      rd = v;
      lat = 2;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      lat = (nb == 4) ? 2 : 3;
    end
  endtask

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd_obs, output logic err_obs);
    logic [31:0] exp_rd;
    bit exp_err;
    int exp_lat, lat, w, we0;
    model_access(we, f3, a, wd, exp_rd, exp_err, exp_lat);
    w = 0;
    while (!bus.req_ready && w < 20) begin @(posedge clk); #1; w++; end
    chk("ready_before_req", 32'(bus.req_ready), 32'd1);
    we0 = we_cnt;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (!exp_err) chk("ram_addr", 32'(bus.ram_addr), 32'({a[ADDR_W-1:2], 2'b00}));
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
    chk("resp_rdata", bus.resp_rdata, exp_rd);
    rd_obs = bus.resp_rdata;
    err_obs = bus.resp_err;
    chk("ram_writes", 32'(we_cnt - we0), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) chk("ram_word", mem[a[ADDR_W-1:2]], ref_word(a));
    @(posedge clk); #1;
    chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic err;
    int acc0, w;
    bit we;
    logic [2:0] f3;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int i = 0; i < SIZE/4; i++) {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]} = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", bus.ram_data_write, 32'd0);
    @(negedge clk);
    fill = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, rd, err);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, err);
    chk("lw_value", rd, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h13, 32'h0000_00AB, rd, err);
    chk("sb_word", mem[4], 32'hAB22_3344);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, err);
    chk("lb_value", rd, 32'hFFFF_FFAB);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, err);
    chk("lbu_value", rd, 32'h0000_00AB);
    do_req(1'b1, 3'b001, 32'h12, 32'h0000_8001, rd, err);
    chk("sh_word", mem[4], 32'h8001_3344);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, err);
    chk("lh_value", rd, 32'hFFFF_8001);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, rd, err);
    chk("lhu_value", rd, 32'h0000_8001);

    do_req(1'b0, 3'b010, 32'h11, 32'h0, rd, err);
    chk("err_lw_misaligned", 32'(err), 32'd1);
    do_req(1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF, rd, err);
    chk("err_sh_misaligned", 32'(err), 32'd1);
    do_req(1'b0, 3'b000, 32'h400, 32'h0, rd, err);
    chk("err_lb_range", 32'(err), 32'd1);
    do_req(1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF, rd, err);
    chk("err_store_f3", 32'(err), 32'd1);

    // A request held valid through a busy SB is accepted once, then again in the IDLE after DONE.
    acc0 = acc_cnt;
    model_access(1'b1, 3'b000, 32'h41, 32'h0000_005C, rd, we, w);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h41; bus.req_wdata = 32'h0000_005C;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_single_accept", 32'(acc_cnt - acc0), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("hold_second_accept", 32'(acc_cnt - acc0), 32'd2);
    w = 0;
    while (!bus.resp_valid && w < 10) begin @(posedge clk); #1; w++; end
    chk("hold_resp_seen", 32'(bus.resp_valid), 32'd1);
    @(posedge clk); #1;
    chk("hold_word", mem[16], ref_word(32'h40));

    // Reset while ram_we is high must cancel the write.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("midwrite_we_high", 32'(bus.ram_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("midwrite_we_drop", 32'(bus.ram_we), 32'd0);
    chk("midwrite_ready", 32'(bus.req_ready), 32'd1);
    chk("midwrite_resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("midwrite_word", mem[8], ref_word(32'h20));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      wd = $urandom;
      case ($urandom % 8)
        0:       a = $urandom;
        1:       a = SIZE + ($urandom % 16);
        default: a = $urandom_range(0, SIZE - 1);
      endcase
      if ($urandom % 2 == 1) a = a & 32'hFFFF_FFFC;
      do_req(we, f3, a, wd, rd, err);
    end

    for (int i = 0; i < SIZE/4; i++) chk("final_sweep", mem[i], ref_word(32'(4 * i)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
